// File: rtl/decode_ctrl_pipe.sv
// Registered MIPS instruction-decode stage (ID/EX) with load-use stall, valid/ready
// backpressure, flush, sticky HALT and an LL/SC link reservation (DECODE_LLSC_EN).
module decode_ctrl_pipe #(
    parameter int REG_IDX_W   = 5,
    parameter int LINK_ADDR_W = 30
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   instr_valid,
    input  logic [31:0]            instr,
    output logic                   instr_ready,
    input  logic                   flush,
    input  logic                   ex_ready,
    output logic                   ex_valid,
    output logic [3:0]             ex_aluop,
    output logic [REG_IDX_W-1:0]   ex_wsel,
    output logic                   ex_regwr,
    output logic                   ex_memrd,
    output logic                   ex_memwr,
    output logic                   ex_use_imm,
    output logic                   ex_use_shamt,
    output logic                   ex_halt,
    output logic                   ex_illegal,
    output logic [1:0]             ex_br,
    output logic [1:0]             ex_jump,
    output logic [31:0]            ex_imm,
    input  logic                   link_set,
    input  logic [LINK_ADDR_W-1:0] link_addr,
    input  logic                   sc_check,
    output logic                   sc_success,
    input  logic                   snoop_inv,
    input  logic [LINK_ADDR_W-1:0] snoop_addr
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                           ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
                           ALU_SLL = 4'd8, ALU_SRL = 4'd9;
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                           OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
                           OP_LW = 6'h23, OP_SW = 6'h2B, OP_LL = 6'h30, OP_SC = 6'h38,
                           OP_HALT = 6'h3F;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20,
                           FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
                           FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A,
                           FN_SLTU = 6'h2B;

    logic [5:0]           opc, fn;
    logic [REG_IDX_W-1:0] rs, rt, rd;
    logic [31:0]          imm_sx, imm_zx;

    assign opc    = instr[31:26];
    assign fn     = instr[5:0];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign imm_sx = {{16{instr[15]}}, instr[15:0]};
    assign imm_zx = {16'h0000, instr[15:0]};

    logic [3:0]           d_aluop_p0;
    logic [REG_IDX_W-1:0] d_wsel_p0;
    logic                 d_regwr_p0, d_memrd_p0, d_memwr_p0, d_use_imm_p0, d_use_shamt_p0;
    logic                 d_halt_p0, d_illegal_p0, rt_src_p0;
    logic [1:0]           d_br_p0, d_jump_p0;
    logic [31:0]          d_imm_p0;

    // Decode of the instruction waiting in IF/ID
    always_comb begin
        d_aluop_p0     = ALU_ADD;
        d_wsel_p0      = rt;
        d_regwr_p0     = 1'b0;
        d_memrd_p0     = 1'b0;
        d_memwr_p0     = 1'b0;
        d_use_imm_p0   = 1'b0;
        d_use_shamt_p0 = 1'b0;
        d_halt_p0      = 1'b0;
        d_illegal_p0   = 1'b0;
        d_br_p0        = 2'b00;
        d_jump_p0      = 2'b00;
        d_imm_p0       = 32'h0;
        rt_src_p0      = 1'b0;
        case (opc)
            OP_RTYPE: begin
                d_wsel_p0  = rd;
                d_regwr_p0 = 1'b1;
                rt_src_p0  = 1'b1;
                case (fn)
                    FN_ADD, FN_ADDU: d_aluop_p0 = ALU_ADD;
                    FN_SUB, FN_SUBU: d_aluop_p0 = ALU_SUB;
                    FN_AND:  d_aluop_p0 = ALU_AND;
                    FN_OR:   d_aluop_p0 = ALU_OR;
                    FN_XOR:  d_aluop_p0 = ALU_XOR;
                    FN_NOR:  d_aluop_p0 = ALU_NOR;
                    FN_SLT:  d_aluop_p0 = ALU_SLT;
                    FN_SLTU: d_aluop_p0 = ALU_SLTU;
                    FN_SLL:  begin d_aluop_p0 = ALU_SLL; d_use_shamt_p0 = 1'b1; end
                    FN_SRL:  begin d_aluop_p0 = ALU_SRL; d_use_shamt_p0 = 1'b1; end
                    FN_JR:   begin d_jump_p0 = 2'b10; d_regwr_p0 = 1'b0; end
                    default: d_illegal_p0 = 1'b1;
                endcase
            end
            OP_J:     begin d_jump_p0 = 2'b01; d_wsel_p0 = '0; d_imm_p0 = {6'b0, instr[25:0]}; end
            OP_JAL: begin
                d_jump_p0  = 2'b01;
                d_regwr_p0 = 1'b1;
                d_wsel_p0  = REG_IDX_W'(31);
                d_imm_p0   = {6'b0, instr[25:0]};
            end
            OP_BEQ:   begin d_br_p0 = 2'b01; d_aluop_p0 = ALU_SUB; d_imm_p0 = imm_sx; rt_src_p0 = 1'b1; end
            OP_BNE:   begin d_br_p0 = 2'b10; d_aluop_p0 = ALU_SUB; d_imm_p0 = imm_sx; rt_src_p0 = 1'b1; end
            OP_ADDIU: begin d_regwr_p0 = 1'b1; d_use_imm_p0 = 1'b1; d_imm_p0 = imm_sx; end
            OP_SLTI:  begin d_regwr_p0 = 1'b1; d_use_imm_p0 = 1'b1; d_imm_p0 = imm_sx; d_aluop_p0 = ALU_SLT; end
            OP_SLTIU: begin d_regwr_p0 = 1'b1; d_use_imm_p0 = 1'b1; d_imm_p0 = imm_sx; d_aluop_p0 = ALU_SLTU; end
            OP_ANDI:  begin d_regwr_p0 = 1'b1; d_use_imm_p0 = 1'b1; d_imm_p0 = imm_zx; d_aluop_p0 = ALU_AND; end
            OP_ORI:   begin d_regwr_p0 = 1'b1; d_use_imm_p0 = 1'b1; d_imm_p0 = imm_zx; d_aluop_p0 = ALU_OR; end
            OP_XORI:  begin d_regwr_p0 = 1'b1; d_use_imm_p0 = 1'b1; d_imm_p0 = imm_zx; d_aluop_p0 = ALU_XOR; end
            // rs field of LUI is zero, so ALU_ADD yields the shifted immediate
            OP_LUI:   begin d_regwr_p0 = 1'b1; d_use_imm_p0 = 1'b1; d_imm_p0 = {instr[15:0], 16'h0}; end
            OP_LW:    begin d_regwr_p0 = 1'b1; d_memrd_p0 = 1'b1; d_use_imm_p0 = 1'b1; d_imm_p0 = imm_sx; end
            OP_SW:    begin d_memwr_p0 = 1'b1; d_use_imm_p0 = 1'b1; d_imm_p0 = imm_sx; rt_src_p0 = 1'b1; end
`ifdef DECODE_LLSC_EN
            OP_LL:    begin d_regwr_p0 = 1'b1; d_memrd_p0 = 1'b1; d_use_imm_p0 = 1'b1; d_imm_p0 = imm_sx; end
            OP_SC: begin
                d_regwr_p0   = 1'b1;
                d_memwr_p0   = 1'b1;
                d_use_imm_p0 = 1'b1;
                d_imm_p0     = imm_sx;
                rt_src_p0    = 1'b1;
            end
`else
            OP_SC:    begin d_illegal_p0 = 1'b1; rt_src_p0 = 1'b1; end
`endif
            OP_HALT:  begin d_halt_p0 = 1'b1; d_wsel_p0 = '0; end
            default:  d_illegal_p0 = 1'b1;
        endcase
        if (d_illegal_p0) begin
            d_aluop_p0     = ALU_ADD;
            d_wsel_p0      = '0;
            d_regwr_p0     = 1'b0;
            d_memrd_p0     = 1'b0;
            d_memwr_p0     = 1'b0;
            d_use_imm_p0   = 1'b0;
            d_use_shamt_p0 = 1'b0;
            d_br_p0        = 2'b00;
            d_jump_p0      = 2'b00;
            d_imm_p0       = 32'h0;
        end
    end

    logic halted, hazard, advance, accept;

    assign hazard      = ex_valid && ex_memrd && (ex_wsel != '0) &&
                         ((ex_wsel == rs) || ((ex_wsel == rt) && rt_src_p0));
    assign advance     = !ex_valid || ex_ready;
    assign instr_ready = advance && !hazard && !halted && !flush;
    assign accept      = instr_valid && instr_ready;

    // ID/EX register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_valid     <= 1'b0;
            ex_aluop     <= ALU_ADD;
            ex_wsel      <= '0;
            ex_regwr     <= 1'b0;
            ex_memrd     <= 1'b0;
            ex_memwr     <= 1'b0;
            ex_use_imm   <= 1'b0;
            ex_use_shamt <= 1'b0;
            ex_halt      <= 1'b0;
            ex_illegal   <= 1'b0;
            ex_br        <= 2'b00;
            ex_jump      <= 2'b00;
            ex_imm       <= 32'h0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (advance) begin
            ex_valid <= accept;
            if (accept) begin
                ex_aluop     <= d_aluop_p0;
                ex_wsel      <= d_wsel_p0;
                ex_regwr     <= d_regwr_p0;
                ex_memrd     <= d_memrd_p0;
                ex_memwr     <= d_memwr_p0;
                ex_use_imm   <= d_use_imm_p0;
                ex_use_shamt <= d_use_shamt_p0;
                ex_halt      <= d_halt_p0;
                ex_illegal   <= d_illegal_p0;
                ex_br        <= d_br_p0;
                ex_jump      <= d_jump_p0;
                ex_imm       <= d_imm_p0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                     halted <= 1'b0;
        else if (accept && d_halt_p0) halted <= 1'b1;
    end

`ifdef DECODE_LLSC_EN
    typedef enum logic {LINK_IDLE, LINK_LINKED} link_state_t;
    link_state_t            link_state, link_state_nxt;
    logic [LINK_ADDR_W-1:0] link_addr_q, link_addr_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            link_state  <= LINK_IDLE;
            link_addr_q <= '0;
        end else begin
            link_state  <= link_state_nxt;
            link_addr_q <= link_addr_nxt;
        end
    end

    // A same-cycle link_set overrides the clear caused by sc_check
    always_comb begin
        link_state_nxt = link_state;
        link_addr_nxt  = link_addr_q;
        if (link_set) begin
            link_state_nxt = LINK_LINKED;
            link_addr_nxt  = link_addr;
        end else if (link_state == LINK_LINKED &&
                     (sc_check || (snoop_inv && snoop_addr == link_addr_q))) begin
            link_state_nxt = LINK_IDLE;
        end
    end

    assign sc_success = sc_check && (link_state == LINK_LINKED) && (link_addr == link_addr_q);
`else
    logic unused_link;
    assign unused_link = ^{link_set, link_addr, sc_check, snoop_inv, snoop_addr};
    assign sc_success  = 1'b0;
`endif
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Randomized and directed bench for decode_ctrl_pipe against a mnemonic-level reference model.
module tb_decode_ctrl_pipe;
    localparam int RW = 5;
    localparam int AW = 30;
    localparam logic [3:0] A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3, A_XOR = 4, A_NOR = 5,
                           A_SLT = 6, A_SLTU = 7, A_SLL = 8, A_SRL = 9;
    localparam logic [5:0] FN_TAB [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                           6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h08};
    localparam logic [5:0] OP_TAB [15] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0A, 6'h0B,
                                           6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h30, 6'h38};

    typedef struct packed {
        logic [3:0]    aluop;
        logic [RW-1:0] wsel;
        logic          regwr, memrd, memwr, use_imm, use_shamt, halt, illegal;
        logic [1:0]    br, jump;
        logic [31:0]   imm;
    } bundle_t;

    logic CLK = 1'b0;
    logic RST;
    logic instr_valid, flush, ex_ready, instr_ready, ex_valid;
    logic [31:0] instr, ex_imm;
    logic [3:0] ex_aluop;
    logic [RW-1:0] ex_wsel;
    logic ex_regwr, ex_memrd, ex_memwr, ex_use_imm, ex_use_shamt, ex_halt, ex_illegal;
    logic [1:0] ex_br, ex_jump;
    logic link_set, sc_check, sc_success, snoop_inv;
    logic [AW-1:0] link_addr, snoop_addr;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    decode_ctrl_pipe dut (
        .CLK(CLK), .RST(RST), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_aluop(ex_aluop),
        .ex_wsel(ex_wsel), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr),
        .ex_use_imm(ex_use_imm), .ex_use_shamt(ex_use_shamt), .ex_halt(ex_halt),
        .ex_illegal(ex_illegal), .ex_br(ex_br), .ex_jump(ex_jump), .ex_imm(ex_imm),
        .link_set(link_set), .link_addr(link_addr), .sc_check(sc_check),
        .sc_success(sc_success), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr)
    );

    function automatic string mnem(input logic [31:0] i);
        if (i[31:26] == 6'h00) begin
            case (i[5:0])
                6'h20: return "add";  6'h21: return "addu"; 6'h22: return "sub";
                6'h23: return "subu"; 6'h24: return "and";  6'h25: return "or";
                6'h26: return "xor";  6'h27: return "nor";  6'h2A: return "slt";
                6'h2B: return "sltu"; 6'h00: return "sll";  6'h02: return "srl";
                6'h08: return "jr";
                default: return "ill";
            endcase
        end
        case (i[31:26])
            6'h02: return "j";     6'h03: return "jal";   6'h04: return "beq";
            6'h05: return "bne";   6'h09: return "addiu"; 6'h0A: return "slti";
            6'h0B: return "sltiu"; 6'h0C: return "andi";  6'h0D: return "ori";
            6'h0E: return "xori";  6'h0F: return "lui";   6'h23: return "lw";
            6'h2B: return "sw";    6'h3F: return "halt";
`ifdef DECODE_LLSC_EN
            6'h30: return "ll";    6'h38: return "sc";
`endif
            default: return "ill";
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input string m);
        if (m == "sub" || m == "subu" || m == "beq" || m == "bne") return A_SUB;
        if (m == "and" || m == "andi") return A_AND;
        if (m == "or"  || m == "ori")  return A_OR;
        if (m == "xor" || m == "xori") return A_XOR;
        if (m == "nor")                return A_NOR;
        if (m == "slt" || m == "slti") return A_SLT;
        if (m == "sltu" || m == "sltiu") return A_SLTU;
        if (m == "sll") return A_SLL;
        if (m == "srl") return A_SRL;
        return A_ADD;
    endfunction

    function automatic bundle_t ref_decode(input logic [31:0] i);
        bundle_t b;
        string m;
        b = '0;
        m = mnem(i);
        if (m == "ill") begin
            b.illegal = 1'b1;
            return b;
        end
        b.aluop = alu_of(m);
        if (i[31:26] == 6'h00) begin
            b.wsel      = i[15:11];
            b.regwr     = (m != "jr");
            b.use_shamt = (m == "sll" || m == "srl");
            b.jump      = (m == "jr") ? 2'b10 : 2'b00;
            return b;
        end
        b.wsel    = (m == "jal") ? RW'(31) : (m == "j" || m == "halt") ? '0 : i[20:16];
        b.regwr   = (m == "addiu" || m == "slti" || m == "sltiu" || m == "andi" || m == "ori" ||
                     m == "xori" || m == "lui" || m == "lw" || m == "ll" || m == "sc" || m == "jal");
        b.memrd   = (m == "lw" || m == "ll");
        b.memwr   = (m == "sw" || m == "sc");
        b.use_imm = !(m == "beq" || m == "bne" || m == "j" || m == "jal" || m == "halt");
        b.halt    = (m == "halt");
        b.br      = (m == "beq") ? 2'b01 : (m == "bne") ? 2'b10 : 2'b00;
        b.jump    = (m == "j" || m == "jal") ? 2'b01 : 2'b00;
        if (m == "andi" || m == "ori" || m == "xori") b.imm = {16'h0, i[15:0]};
        else if (m == "lui")                          b.imm = {i[15:0], 16'h0};
        else if (m == "j" || m == "jal")              b.imm = {6'h0, i[25:0]};
        else if (m == "halt")                         b.imm = 32'h0;
        else                                          b.imm = {{16{i[15]}}, i[15:0]};
        return b;
    endfunction

    function automatic logic rt_is_src(input logic [31:0] i);
        return i[31:26] == 6'h00 || i[31:26] == 6'h04 || i[31:26] == 6'h05 ||
               i[31:26] == 6'h2B || i[31:26] == 6'h38;
    endfunction

    // Reference state: what the EX slot should hold, halt and reservation status
    logic    m_valid, m_halted, m_linked;
    bundle_t m_b;
    logic [AW-1:0] m_laddr;
    logic    ma_acc;

    function automatic logic ref_hazard(input logic [31:0] i);
        return m_valid && m_b.memrd && m_b.wsel != 0 &&
               (m_b.wsel == i[25:21] || (m_b.wsel == i[20:16] && rt_is_src(i)));
    endfunction

    function automatic logic exp_ready();
        return (!m_valid || ex_ready) && !ref_hazard(instr) && !m_halted && !flush;
    endfunction

    function automatic logic exp_sc();
`ifdef DECODE_LLSC_EN
        return sc_check && m_linked && link_addr == m_laddr;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_valid <= 1'b0; m_b <= '0; m_halted <= 1'b0; m_linked <= 1'b0; m_laddr <= '0;
        end else begin
            ma_acc = instr_valid && exp_ready();
            if (flush)                          m_valid <= 1'b0;
            else if (!m_valid || ex_ready)      m_valid <= ma_acc;
            if (!flush && ma_acc)               m_b <= ref_decode(instr);
            if (ma_acc && mnem(instr) == "halt") m_halted <= 1'b1;
            if (link_set) begin
                m_linked <= 1'b1; m_laddr <= link_addr;
            end else if (m_linked && (sc_check || (snoop_inv && snoop_addr == m_laddr))) begin
                m_linked <= 1'b0;
            end
        end
    end

    function automatic bundle_t dut_bundle();
        return {ex_aluop, ex_wsel, ex_regwr, ex_memrd, ex_memwr, ex_use_imm, ex_use_shamt,
                ex_halt, ex_illegal, ex_br, ex_jump, ex_imm};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic er, input logic fl);
        instr_valid = v; instr = i; ex_ready = er; flush = fl;
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick(); tick();
    endtask

    task automatic test_reset();
        link_set = 0; sc_check = 0; snoop_inv = 0; link_addr = '0; snoop_addr = '0;
        drive(1'b1, 32'h2422FFFF, 1'b1, 1'b0);
        RST = 1'b1;
        tick(); tick();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%0b exp=0", ex_valid); end
        checks++; if (dut_bundle() !== bundle_t'(0)) begin failures++; $display("FAIL reset_bundle got=%0h exp=0", dut_bundle()); end
        checks++; if (sc_success !== 1'b0) begin failures++; $display("FAIL reset_sc got=%0b exp=0", sc_success); end
        RST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", instr_ready); end
        tick();
    endtask

    task automatic test_addiu();
        drain();
        drive(1'b1, 32'h2422FFFF, 1'b1, 1'b0);
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL addiu_ready got=%0b exp=1", instr_ready); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL addiu_valid got=%0b exp=1", ex_valid); end
        checks++; if (ex_aluop !== A_ADD) begin failures++; $display("FAIL addiu_aluop got=%0d exp=%0d", ex_aluop, A_ADD); end
        checks++; if (ex_imm !== 32'hFFFFFFFF) begin failures++; $display("FAIL addiu_imm got=%0h exp=ffffffff", ex_imm); end
        checks++; if (ex_wsel !== 5'd2) begin failures++; $display("FAIL addiu_wsel got=%0d exp=2", ex_wsel); end
        checks++; if (ex_regwr !== 1'b1 || ex_use_imm !== 1'b1) begin failures++; $display("FAIL addiu_flags got=%0b%0b exp=11", ex_regwr, ex_use_imm); end
    endtask

    task automatic test_load_use();
        drain();
        drive(1'b1, 32'h8C230000, 1'b1, 1'b0);       // LW $3,0($1)
        tick();
        drive(1'b1, 32'h00652020, 1'b1, 1'b0);       // ADD $4,$3,$5
        #1;
        checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL lu_stall got=%0b exp=0", instr_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%0b exp=0", ex_valid); end
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL lu_release got=%0b exp=1", instr_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_wsel !== 5'd4 || ex_memrd !== 1'b0) begin
            failures++; $display("FAIL lu_add_in_ex got=%0b/%0d/%0b exp=1/4/0", ex_valid, ex_wsel, ex_memrd); end
        // load into $0 never stalls
        drain();
        drive(1'b1, 32'h8C200000, 1'b1, 1'b0);       // LW $0,0($1)
        tick();
        drive(1'b1, 32'h00052020, 1'b1, 1'b0);       // ADD $4,$0,$5
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL lu_zero_reg got=%0b exp=1", instr_ready); end
        tick();
        // flush on the hazard cycle
        drive(1'b1, 32'h8C230000, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h00652020, 1'b1, 1'b1);
        tick();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL lu_flush got=%0b exp=0", ex_valid); end
    endtask

    task automatic test_backpressure();
        drain();
        drive(1'b1, 32'h34268001, 1'b1, 1'b0);       // ORI $6,$1,0x8001
        tick();
        drive(1'b1, 32'h2422FFFF, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL bp_ready c=%0d got=%0b exp=0", c, instr_ready); end
            tick();
            checks++; if (ex_valid !== 1'b1 || ex_aluop !== A_OR || ex_imm !== 32'h8001 || ex_wsel !== 5'd6) begin
                failures++; $display("FAIL bp_hold c=%0d got=%0b/%0d/%0h/%0d exp=1/3/8001/6", c, ex_valid, ex_aluop, ex_imm, ex_wsel); end
        end
        ex_ready = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL bp_resume got=%0b exp=1", instr_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_imm !== 32'hFFFFFFFF) begin failures++; $display("FAIL bp_next got=%0b/%0h exp=1/ffffffff", ex_valid, ex_imm); end
    endtask

    task automatic test_flush();
        drain();
        drive(1'b1, 32'h34268001, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h2422FFFF, 1'b0, 1'b1);
        #1;
        checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", instr_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", ex_valid); end
        drive(1'b1, 32'h2422FFFF, 1'b1, 1'b0);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_imm !== 32'hFFFFFFFF) begin failures++; $display("FAIL flush_after got=%0b/%0h exp=1/ffffffff", ex_valid, ex_imm); end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        logic [5:0]  op;
        i = $urandom;
        i[25:21] = 5'($urandom_range(0, 3));
        i[20:16] = 5'($urandom_range(0, 3));
        i[15:11] = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0: begin op = 6'($urandom); if (op == 6'h3F) op = 6'h3E; i[31:26] = op; end
            1, 2, 3, 4: begin i[31:26] = 6'h00; i[5:0] = FN_TAB[$urandom_range(0, 12)]; end
            5, 6: i[31:26] = 6'h23;
            default: i[31:26] = OP_TAB[$urandom_range(0, 14)];
        endcase
        return i;
    endfunction

    task automatic test_random();
        bundle_t exp_b;
        drain();
        for (int n = 0; n < 600; n++) begin
            checks++; if (ex_valid !== m_valid) begin failures++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, ex_valid, m_valid); end
            if (m_valid) begin
                exp_b = m_b;
                checks++; if (dut_bundle() !== exp_b) begin failures++; $display("FAIL rnd_bundle n=%0d got=%0h exp=%0h", n, dut_bundle(), exp_b); end
            end
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            link_set   = $urandom_range(0, 7) == 0;
            sc_check   = $urandom_range(0, 5) == 0;
            snoop_inv  = $urandom_range(0, 7) == 0;
            link_addr  = AW'($urandom_range(0, 1) ? 'h100 : 'h104);
            snoop_addr = AW'($urandom_range(0, 1) ? 'h100 : 'h104);
            #1;
            checks++; if (instr_ready !== exp_ready()) begin failures++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, instr_ready, exp_ready()); end
            checks++; if (sc_success !== exp_sc()) begin failures++; $display("FAIL rnd_sc n=%0d got=%0b exp=%0b", n, sc_success, exp_sc()); end
            tick();
        end
        link_set = 0; sc_check = 0; snoop_inv = 0;
    endtask

    task automatic test_llsc();
        drain();
`ifdef DECODE_LLSC_EN
        for (int pass = 0; pass < 2; pass++) begin
            link_set = 1; link_addr = AW'('h100);
            tick();
            link_set = 0;
            snoop_inv = (pass == 0); snoop_addr = AW'('h100);
            tick();
            snoop_inv = 0; sc_check = 1; link_addr = AW'('h100);
            #1;
            checks++; if (sc_success !== (pass == 1)) begin failures++; $display("FAIL llsc_pass%0d got=%0b exp=%0b", pass, sc_success, pass == 1); end
            tick();
            #1;
            checks++; if (sc_success !== 1'b0) begin failures++; $display("FAIL llsc_cleared%0d got=%0b exp=0", pass, sc_success); end
            sc_check = 0;
            tick();
        end
        drive(1'b1, 32'hC0220004, 1'b1, 1'b0);       // LL $2,4($1)
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (ex_memrd !== 1'b1 || ex_regwr !== 1'b1 || ex_illegal !== 1'b0) begin
            failures++; $display("FAIL ll_decode got=%0b%0b%0b exp=110", ex_memrd, ex_regwr, ex_illegal); end
`else
        link_set = 1; link_addr = AW'('h100);
        tick();
        link_set = 0; sc_check = 1;
        #1;
        checks++; if (sc_success !== 1'b0) begin failures++; $display("FAIL sc_tied got=%0b exp=0", sc_success); end
        sc_check = 0;
        drive(1'b1, 32'hC0220004, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (ex_illegal !== 1'b1 || ex_regwr !== 1'b0 || ex_memrd !== 1'b0) begin
            failures++; $display("FAIL ll_illegal got=%0b%0b%0b exp=100", ex_illegal, ex_regwr, ex_memrd); end
`endif
    endtask

    task automatic test_halt();
        drain();
        drive(1'b1, 32'hFC000000, 1'b1, 1'b0);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_halt !== 1'b1 || ex_regwr !== 1'b0) begin
            failures++; $display("FAIL halt_ex got=%0b%0b%0b exp=110", ex_valid, ex_halt, ex_regwr); end
        drive(1'b1, 32'h2422FFFF, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL halt_block c=%0d got=%0b exp=0", c, instr_ready); end
            tick();
        end
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL halt_empty got=%0b exp=0", ex_valid); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL halt_release got=%0b exp=1", instr_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_imm !== 32'hFFFFFFFF) begin failures++; $display("FAIL halt_after got=%0b/%0h exp=1/ffffffff", ex_valid, ex_imm); end
    endtask

    initial begin
        RST = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        test_reset();
        test_addiu();
        test_load_use();
        test_backpressure();
        test_flush();
        test_random();
        test_llsc();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered instruction-decode stage for the pipelined MIPS datapath: decodes a 32-bit instruction into the datapath control bundle and holds it in the ID/EX register. It also detects load-use hazards, honours valid/ready backpressure and flush, and tracks the LL/SC link reservation. It sits between the IF/ID register and the execute stage, replacing single-cycle combinational decode.

## Interface
- REG_IDX_W, 5: register index width (31 = link register for JAL).
- LINK_ADDR_W, 30: word-address width of the LL/SC reservation.
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- instr_valid  in  1  IF/ID holds a valid instruction.
- instr  in  32  instruction word; opcode/funct/aluop encodings are those of cpu_types_pkg.
- instr_ready  out  1  instruction accepted this cycle when high with instr_valid.
- flush  in  1  squash EX contents and refuse input (branch/jump taken).
- ex_ready  in  1  execute stage consumes ex_* this cycle.
- ex_valid  out  1  ex_* holds a real instruction.
- ex_aluop  out  4  ALU operation.
- ex_wsel  out  REG_IDX_W  destination: rd (R-type), rt (I-type), 31 (JAL).
- ex_regwr, ex_memrd, ex_memwr, ex_use_imm, ex_use_shamt, ex_halt, ex_illegal  out  1 each  control flags.
- ex_br  out  2  00 none, 01 BEQ, 10 BNE.
- ex_jump  out  2  00 none, 01 J/JAL, 10 JR.
- ex_imm  out  32  immediate, already sign-, zero- or LUI-extended.
- link_set  in  1  LL completing in MEM; load reservation with link_addr.
- link_addr  in  LINK_ADDR_W  LL/SC word address.
- sc_check  in  1  SC in MEM, compare against link_addr.
- sc_success  out  1  combinational: sc_check & link_valid & link_addr == stored address.
- snoop_inv  in  1, snoop_addr  in  LINK_ADDR_W  coherence invalidate.

## Operation
- accept = instr_valid & instr_ready; advance = ~ex_valid | ex_ready.
- instr_ready = advance & ~hazard & ~halted & ~flush.
- EX register update priority: flush → ex_valid=0; else advance & accept → load decoded bundle, ex_valid=1; else advance → ex_valid=0 (bubble); else hold.
- hazard = ex_valid & ex_memrd & ex_wsel != 0 & (ex_wsel == rs | (ex_wsel == rt & rt is source)); rt is source for R-type, BEQ, BNE, SW, SC.
- Decode: R-type funct → ALU op (SLL/SRL set ex_use_shamt, JR sets ex_jump=10, regwr=0); ADDIU/SLTI/SLTIU/LW/SW/LL/SC sign-extend; ANDI/ORI/XORI zero-extend; LUI → imm<<16, ALU_ADD with zero source; BEQ/BNE/J/HALT/SW regwr=0.
- Undefined opcode/funct: ex_illegal=1, all write/memory/branch flags 0.
- halted: set when HALT accepted; sticky until RST; blocks further accepts.
- Link FSM: IDLE → (link_set) LINKED; LINKED → IDLE on sc_check (success or not) or snoop_inv with matching address; link_set in LINKED reloads address. sc_check and link_set same cycle: sc_check evaluated against old state, then link_set wins.

## Timing
- Decode latency 1 cycle: accept on edge N → ex_* valid after edge N.
- RST: ex_valid, all ex_* flags, ex_imm, ex_wsel, ex_br, ex_jump = 0; ex_aluop = ALU_ADD; halted=0; link IDLE; instr_ready follows its equation (1 once RST deasserts).
- Hazard stall exactly 1 cycle per load-use pair; bubble inserted when advance.
- ex_ready low: ex_* held stable, instr_ready low.
- flush during hazard or backpressure: flush wins; ex_valid=0 next cycle.
- Reset mid-stall: all state cleared, pending instruction not consumed.

## Configuration
- DECODE_LLSC_EN defined: LL/SC decoded (LL as load, SC as store with regwr), link FSM and sc_success present.
- Undefined: LL/SC decode as illegal, link register removed, sc_success tied 0, link/snoop inputs ignored.

## Test plan
- ADDIU $2,$1,-1 (0x2422FFFF), ex_ready=1 → next cycle ex_valid=1, ex_aluop=ALU_ADD, ex_imm=0xFFFFFFFF, ex_wsel=2, ex_regwr=1.
- LW $3,0($1) then ADD $4,$3,$5 → instr_ready=0 one cycle, one bubble (ex_valid=0), ADD enters EX following cycle.
- ex_ready=0 for 3 cycles with ORI in EX → ex_* unchanged, instr_ready=0, then ORI consumed and next accepted.
- flush asserted with valid EX and pending instruction → ex_valid=0 next cycle, instruction not accepted.
- HALT accepted → ex_halt=1; subsequent instr_valid never accepted until RST pulse.
- (DECODE_LLSC_EN) link_set addr 0x100, snoop_inv addr 0x100, sc_check addr 0x100 → sc_success=0; repeat without snoop → sc_success=1.
